// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder:
//   - XLEN            : data/address width (also available as the `XLEN macro)
//   - LEN_* encodings : write size field (byte, half, word, reserved)
//   - lane_mask()     : write size + byte offset -> 4-bit byte-lane enable
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package dmem_responder_pkg;

  localparam int XLEN = `XLEN;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;
  localparam logic [1:0] LEN_RSVD = 2'd3;

  // Byte lanes touched by an access of size len at byte offset offset.
  // Misaligned combinations are rejected by the caller before this is used.
  function automatic logic [3:0] lane_mask(input logic [1:0] len,
                                           input logic [1:0] offset);
    logic [3:0] mask;
    case (len)
      LEN_BYTE: mask = 4'b0001 << offset;
      LEN_HALF: mask = 4'b0011 << offset;
      LEN_WORD: mask = 4'b1111;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// -----------------------------------------------------------------------------
// dmem_sram_bank
// Four byte-wide RAM arrays sharing one word address, with a per-lane write
// enable and a synchronous (registered) read. Read-during-write to the same
// word returns the old contents; the caller forwards write data itself.
// Kept as a plain behavioural model so it can be swapped for a vendor macro.
// Ports:
//   clk      : clock
//   i_we     : per-lane write enable
//   i_waddr  : write word address
//   i_wdata  : lane-placed write data
//   i_re     : read enable; o_rdata updates only when set
//   i_raddr  : read word address
//   o_rdata  : read data, one cycle after i_re
// -----------------------------------------------------------------------------
module dmem_sram_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rdata_q;

    // NOTE: the array and its read register have no reset; a RAM macro cannot
    // be cleared in one cycle, and the responder masks stale read data itself.
    always_ff @(posedge clk) begin
      if (i_we[lane]) mem[i_waddr] <= i_wdata[8*lane +: 8];
      if (i_re)       rdata_q      <= mem[i_raddr];
    end

    assign o_rdata[8*lane +: 8] = rdata_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder behind the memory-access stage. Byte/half/word writes
// update selected byte lanes; reads return one cycle later, right-shifted so
// the addressed byte lands at bit 0, with zero-filled upper bytes. A read and
// write to the same word in one cycle is write-first. Out-of-range or
// misaligned requests raise a one-cycle o_err pulse and have no effect.
// Optional build macro: DMEM_STATS_EN adds read/write/error counters.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   i_read_en/i_addr_r: read request and byte address
//   o_data_r          : shifted read data (holds when no read)
//   i_write_en/i_addr_w/i_data_w/i_len_w : write request, address, data, size
//   o_err             : fault pulse for the previous cycle's requests
//   o_rvalid          : registered copy of i_read_en
//   o_rd_cnt/o_wr_cnt/o_err_cnt : statistics (DMEM_STATS_EN only)
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_read_en,
  input  logic [XLEN-1:0] i_addr_r,
  output logic [XLEN-1:0] o_data_r,
  input  logic            i_write_en,
  input  logic [XLEN-1:0] i_addr_w,
  input  logic [XLEN-1:0] i_data_w,
  input  logic [1:0]      i_len_w,
  output logic            o_err,
  output logic            o_rvalid
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]     o_rd_cnt,
  output logic [31:0]     o_wr_cnt,
  output logic [31:0]     o_err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Address decode: 33-bit difference so bit 32 flags addr < BASE_ADDR.
  logic [32:0]   rd_diff, wr_diff;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          rd_fault, rd_ok, wr_fault, wr_ok, wr_misalign;
  logic [3:0]    wr_be;
  logic [31:0]   wr_lane_data;
  logic          unused_addr_bits;

  always_comb begin
    rd_diff      = {1'b0, i_addr_r} - {1'b0, BASE_ADDR};
    wr_diff      = {1'b0, i_addr_w} - {1'b0, BASE_ADDR};
    rd_idx       = rd_diff[AW+1:2];
    wr_idx       = wr_diff[AW+1:2];
    rd_fault     = i_read_en && (rd_diff[32:AW+2] != '0);
    rd_ok        = i_read_en && !rd_fault;
    wr_misalign  = ((i_len_w == LEN_HALF) && (i_addr_w[1:0] == 2'd3)) ||
                   ((i_len_w == LEN_WORD) && (i_addr_w[1:0] != 2'd0)) ||
                   (i_len_w == LEN_RSVD);
    wr_fault     = i_write_en && ((wr_diff[32:AW+2] != '0) || wr_misalign);
    wr_ok        = i_write_en && !wr_fault;
    wr_be        = wr_ok ? lane_mask(i_len_w, i_addr_w[1:0]) : 4'b0000;
    wr_lane_data = i_data_w << {i_addr_w[1:0], 3'b000};
  end

  assign unused_addr_bits = ^{rd_diff[1:0], wr_diff[1:0]};

  logic [31:0] bank_rdata;

  dmem_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .clk     (clk),
    .i_we    (wr_be),
    .i_waddr (wr_idx),
    .i_wdata (wr_lane_data),
    .i_re    (rd_ok),
    .i_raddr (rd_idx),
    .o_rdata (bank_rdata)
  );

  // Read-side pipeline state: everything needed to turn the bank's raw word
  // into o_data_r. It only changes when a read is issued, so o_data_r holds.
  logic        rd_zero_d,  rd_zero_q;    // force output to zero (fault/reset)
  logic [1:0]  rd_shift_d, rd_shift_q;   // byte offset of the read
  logic [3:0]  fwd_be_d,   fwd_be_q;     // lanes overridden by a same-word write
  logic [31:0] fwd_data_d, fwd_data_q;
  logic        err_d,      err_q;
  logic        rvalid_d,   rvalid_q;

  // NOTE: every always_comb output is given a default first so that no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_zero_d  = rd_zero_q;
    rd_shift_d = rd_shift_q;
    fwd_be_d   = fwd_be_q;
    fwd_data_d = fwd_data_q;
    err_d      = rd_fault || wr_fault;
    rvalid_d   = i_read_en;
    if (i_read_en) begin
      rd_zero_d  = rd_fault;
      rd_shift_d = i_addr_r[1:0];
      fwd_be_d   = (wr_ok && (wr_idx == rd_idx)) ? wr_be : 4'b0000;
      fwd_data_d = wr_lane_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_zero_q  <= 1'b1;
      rd_shift_q <= 2'd0;
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= '0;
      err_q      <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      rd_zero_q  <= rd_zero_d;
      rd_shift_q <= rd_shift_d;
      fwd_be_q   <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
      err_q      <= err_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // Write-first merge of the bank word with forwarded lanes, then align.
  logic [31:0] fwd_bits, merged;

  always_comb begin
    fwd_bits = {{8{fwd_be_q[3]}}, {8{fwd_be_q[2]}}, {8{fwd_be_q[1]}}, {8{fwd_be_q[0]}}};
    merged   = (bank_rdata & ~fwd_bits) | (fwd_data_q & fwd_bits);
    o_data_r = rd_zero_q ? '0 : (merged >> {rd_shift_q, 3'b000});
  end

  assign o_err    = err_q;
  assign o_rvalid = rvalid_q;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt_d, rd_cnt_q, wr_cnt_d, wr_cnt_q, err_cnt_d, err_cnt_q;

  always_comb begin
    rd_cnt_d  = rd_cnt_q + 32'(rd_ok);
    wr_cnt_d  = wr_cnt_q + 32'(wr_ok);
    err_cnt_d = err_cnt_q + 32'(rd_fault) + 32'(wr_fault);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_rd_cnt  = rd_cnt_q;
  assign o_wr_cnt  = wr_cnt_q;
  assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the pipeline's memory-access stage.
- Accepts read requests and byte/half/word writes from the memory-access stage. Read data returns exactly one cycle later, right-shifted so the addressed byte sits at bit 0; the requester then does its own sign/zero extension.
- Word-organised byte-lane RAM with same-cycle write forwarding, misalignment/range checking and a registered error flag.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_read_en  in  1  read request this cycle.
- i_addr_r  in  `XLEN  read byte address.
- o_data_r  out  `XLEN  read data, valid in the cycle after i_read_en.
- i_write_en  in  1  write request this cycle.
- i_addr_w  in  `XLEN  write byte address.
- i_data_w  in  `XLEN  write data, right-justified (byte in [7:0], half in [15:0]).
- i_len_w  in  2  write size: 0 byte, 1 half, 2 word, 3 reserved.
- o_err  out  1  registered; high in the cycle after a faulting request.
- o_rvalid  out  1  registered copy of i_read_en.

Behaviour:
- Reset: asynchronous assert forces o_data_r=0, o_err=0 and o_rvalid=0, and discards any in-flight read result. RAM contents are not cleared.
- Index: word index = (addr-BASE_ADDR)>>2. Lane offset = addr[1:0].
- Out of range: offset>=DEPTH_WORDS*4 or addr<BASE_ADDR.
- Misalignment rules:
  - Half access with addr[1:0]==3 is misaligned.
  - Word access with addr[1:0]!=0 is misaligned.
  - i_len_w==3 is a fault.
  - Reads carry no length, so reads check range only.
- Write (i_write_en=1, no fault): at the clock edge, update only the selected byte lanes.
  - Byte: lane k = addr[1:0] takes i_data_w[7:0].
  - Half: lanes k and k+1 take i_data_w[15:0].
  - Word: all four lanes take i_data_w.
- Faulting write: RAM is unchanged and o_err=1 the next cycle.
- Read (i_read_en=1, in range): o_data_r at the next edge = stored word >> (8*addr[1:0]), vacated upper bytes zero-filled.
- Faulting read: o_data_r=0 and o_err=1 the next cycle.
- No read in a cycle: o_data_r holds its previous value; o_rvalid=0.
- Latency: fixed 1 cycle, no backpressure, one request of each type per cycle.
- Simultaneous read and write to the same word: write-first. The read returns the post-write merged word, shifted.
- Simultaneous read and write to different words: both proceed independently.
- o_err is the OR of read and write faults for the cycle. It is a single-cycle pulse and is not sticky.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined: adds outputs o_rd_cnt, o_wr_cnt and o_err_cnt, each 32 bits.
  - Each counter increments by 1 per accepted read, accepted write, or faulting request; a cycle with both a read and a write fault adds 2 to o_err_cnt.
  - Counters wrap at 2^32.
  - Counters clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - length encodings LEN_BYTE=0, LEN_HALF=1, LEN_WORD=2;
  - `XLEN=32;
  - lane-mask function len+offset -> 4-bit byte enable.
- One sub-module, dmem_sram_bank: 4 byte-wide arrays with per-lane write enable and synchronous read, so the array can be swapped for a vendor macro.
- Shifting, forwarding and fault logic stay in dmem_responder.

Test Plan:
- Word write then read, no other writes in between:
  - write addr 0x10, data 0xDEADBEEF, len 2;
  - next cycle read 0x10, then 0x11, then 0x13;
  - expect o_data_r 0xDEADBEEF, then 0x00DEADBE, then 0x000000DE, each one cycle after its read.
- Byte/half merge, starting from 0xDEADBEEF at 0x10:
  - byte write 0x12 data 0xAA, then half write 0x10 data 0x1234;
  - read 0x10 -> 0xDEAA1234.
- Same-cycle collision, starting from 0xDEADBEEF at 0x10:
  - read 0x10 and byte write 0x10 data 0x55 in the same cycle;
  - expect o_data_r 0xDEADBE55 next cycle.
- Faults, starting from 0xDEADBEEF at 0x10:
  - half write 0x13 -> o_err pulses 1 cycle; a later read of 0x10 returns 0xDEADBEEF (unchanged);
  - read addr DEPTH_WORDS*4 -> o_data_r 0, o_err 1;
  - i_len_w=3 -> o_err 1.
- Reset mid-operation: assert rst asynchronously in the same cycle as a read is issued -> o_data_r=0, o_rvalid=0, o_err=0 immediately, and RAM contents are preserved afterwards.
- DMEM_STATS_EN: run 3 reads, 2 writes and 1 misaligned write -> o_rd_cnt=3, o_wr_cnt=2, o_err_cnt=1; after rst all counters read 0.
